alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked ALU that succeeds the fixed 16-bit combinational ALU. Adds generic width, a barrel shifter with variable shift amount, XOR, an iterative unsigned multiplier, N/Z/C/V status flags, and an error flag for illegal opcodes. Operations and results pass through valid/ready handshakes, so the block sits between an instruction-issue stage and a register-writeback stage.

## Interface
- WIDTH, 16, operand/result width; power of two, ≥ 4
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation this cycle
- op  in  4  opcode (see Operation)
- a, b  in  WIDTH  operands; shift/rotate amount is b[SHW-1:0]
- cin  in  1  carry/borrow in (ADD/SUB only)
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- result  out  WIDTH  low result / product low half
- result_hi  out  WIDTH  product high half (MUL); 0 otherwise
- flags  out  4  {N, Z, C, V}
- err  out  1  illegal opcode

## Operation
- Opcodes: 0 ADD a+b+cin; 1 SUB a−b−cin; 2 OR; 3 AND; 4 SHL; 5 SHR (logical); 6 ROL; 7 ROR; 8 XOR; 9 MUL (unsigned, 2·WIDTH product); 10–15 illegal.
- ADD: C = bit WIDTH of the (WIDTH+1)-bit sum. SUB: C = borrow, i.e. bit WIDTH of the (WIDTH+1)-bit difference. V = signed overflow. N = result[WIDTH-1]. Z = (result == 0).
- SHL/SHR: C = last bit shifted out; C = 0 if the amount is 0. Rotates and logic ops: C = 0, V = 0.
- MUL: C = |result_hi; Z over the full 2·WIDTH product; N = result[WIDTH-1]; V = 0.
- Illegal opcode: result = 0, result_hi = 0, flags = {0,1,0,0}, err = 1. Completes with single-cycle latency.
- FSM states:
  - IDLE: in_ready = 1. Accept → DONE, or → MUL if op = 9.
  - MUL: one shift-add step per cycle, down-counter from WIDTH. After the last step → DONE.
  - DONE: out_valid = 1. On out_ready: with in_valid → accept the next operation (DONE or MUL); otherwise → IDLE.
- in_ready = (state == IDLE) | (state == DONE & out_ready).
- Operands, op, and cin are registered on accept. Later input changes have no effect.

## Timing
- Reset values: state IDLE, out_valid 0, in_ready 1 from the first cycle after reset, result/result_hi/flags/err all 0, counter 0.
- Accept occurs on an edge where in_valid & in_ready.
- Latency from accept edge k:
  - Non-MUL: out_valid high from edge k+1.
  - MUL: out_valid high from edge k+WIDTH. in_ready stays low throughout MUL.
- While out_valid & !out_ready, result, result_hi, flags, and err hold stable and in_ready = 0.
- Simultaneous out_ready and in_valid in DONE: the old result retires and the new operation is accepted on the same edge. Peak throughput is one non-MUL operation per cycle.
- rst asserted in any state, including mid-MUL, returns to reset values on that edge. The partial product is discarded and no stale out_valid is produced.

## Structure
- Package alu_pkg holds:
  - the op_t enum (4-bit, codes above)
  - flag index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0
  - the state_t enum
- Sub-module alu_mul_iter (WIDTH parameter): start/busy/done, shift-add datapath, 2·WIDTH product. The top-level FSM sequences it.
- The barrel shifter and add/sub stay in the top level as combinational logic feeding the result registers.

## Test plan
- ADD a = 0x0002, b = 0x0001, cin = 1 → result 0x0004, flags 0000, out_valid exactly 1 cycle after accept.
- SUB a = 0x0000, b = 0x0001, cin = 0 → 0xFFFF, N = 1, C = 1, V = 0. ADD 0x7FFF + 0x0001 → 0x8000, N = 1, V = 1.
- MUL 0x0100 × 0x0100 → result 0x0000, result_hi 0x0001, C = 1, Z = 0. out_valid exactly 16 cycles after accept; in_ready low throughout.
- Backpressure: hold out_ready low for 5 cycles with a result pending → outputs stable, in_ready = 0. Then raise out_ready with in_valid set → retire and accept on the same edge; the next result appears 1 cycle later.
- Reset mid-MUL (assert rst 7 cycles after accept) → next cycle out_valid = 0, in_ready = 1, all outputs 0. The following ADD completes correctly.
- SHL a = 0x8001, b = 1 → 0x0002, C = 1. ROR a = 0x0001, b = 4 → 0x1000, C = 0. op = 0xF → err = 1, result 0, Z = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_OR  = 4'd2,
    OP_AND = 4'd3,
    OP_SHL = 4'd4,
    OP_SHR = 4'd5,
    OP_ROL = 4'd6,
    OP_ROR = 4'd7,
    OP_XOR = 4'd8,
    OP_MUL = 4'd9
  } op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between issue stage, ALU and writeback stage.
interface alu_seq_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [3:0]       flags;
  logic             err;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, result, result_hi, flags, err
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, result, result_hi, flags, err
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, the first
// one folded into the load cycle so a WIDTH-bit multiply takes WIDTH edges in total.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] step_out;

  // Upper half accumulates the multiplicand; lower half holds the unconsumed multiplier bits.
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                              input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    return {sum, p[WIDTH-1:1]};
  endfunction

  assign step_out = step(prod_q, mcand_q);
  assign busy     = (cnt_q != '0);
  assign done     = (cnt_q == CW'(1));
  assign product  = step_out;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    if (start) begin
      mcand_d = a;
      prod_d  = step({{WIDTH{1'b0}}, b}, a);
      cnt_d   = CW'(WIDTH - 1);
    end else if (busy) begin
      prod_d = step_out;
      cnt_d  = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, so an aborted multiply leaves nothing behind.
    if (rst) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked parametrised ALU: single-cycle add/sub/logic/shift ops, iterative MUL,
// N/Z/C/V flags and an illegal-opcode error, with results held until the consumer takes them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic [3:0]         flags_q, flags_d;
  logic               err_q, err_d;

  logic               accept, start_mul, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [3:0]         mul_flags;

  logic [WIDTH-1:0]   alu_res;
  logic [3:0]         alu_flags;
  logic               alu_c, alu_v, alu_err;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     wide;
  logic [2*WIDTH-1:0] dbl;

  assign bus.in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.flags     = flags_q;
  assign bus.err       = err_q;

  assign accept    = bus.in_valid & bus.in_ready;
  assign start_mul = accept & (bus.op == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (start_mul),
    .a       (bus.a),
    .b       (bus.b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath; the extra top bit of `wide` carries C for add/sub/shl.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    wide    = '0;
    dbl     = '0;
    shamt   = bus.b[SHW-1:0];
    case (bus.op)
      OP_ADD: begin
        wide    = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        wide    = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.cin};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_OR:  alu_res = bus.a | bus.b;
      OP_AND: alu_res = bus.a & bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SHL: begin
        wide    = {1'b0, bus.a} << shamt;
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
      end
      OP_SHR: begin
        wide    = {bus.a, 1'b0} >> shamt;
        alu_res = wide[WIDTH:1];
        alu_c   = wide[0];
      end
      OP_ROL: begin
        dbl     = {bus.a, bus.a} << shamt;
        alu_res = dbl[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        dbl     = {bus.a, bus.a} >> shamt;
        alu_res = dbl[WIDTH-1:0];
      end
      OP_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_product[WIDTH-1];
    mul_flags[FLAG_Z] = (mul_product == '0);
    mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (bus.op == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            state_d     = ST_DONE;
            result_d    = alu_res;
            result_hi_d = '0;
            flags_d     = alu_flags;
            err_d       = alu_err;
          end
        end else if (state_q == ST_DONE && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d     = ST_DONE;
          result_d    = mul_product[WIDTH-1:0];
          result_hi_d = mul_product[2*WIDTH-1:WIDTH];
          flags_d     = mul_flags;
          err_d       = 1'b0;
        end else if (!mul_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic [3:0]  flags;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    exp_t        e;
  } vec_t;

  // Reference model: plain integer arithmetic, shifts/rotates one bit at a time.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic cin);
    longint ua, ub, r, s, p, hi;
    int sa, sb, sr, amt;
    bit c, v, z, e;
    exp_t x;
    ua = longint'(a); ub = longint'(b);
    sa = (ua >= 32768) ? int'(ua) - 65536 : int'(ua);
    sb = (ub >= 32768) ? int'(ub) - 65536 : int'(ub);
    amt = int'(ub % W);
    r = 0; hi = 0; c = 0; v = 0; e = 0; p = 0;
    case (op)
      4'd0: begin
        s = ua + ub + longint'(cin); r = s % 65536; c = (s >= 65536);
        sr = sa + sb + int'(cin); v = (sr > 32767) || (sr < -32768);
      end
      4'd1: begin
        s = ua - ub - longint'(cin); c = (s < 0); r = (s + 131072) % 65536;
        sr = sa - sb - int'(cin); v = (sr > 32767) || (sr < -32768);
      end
      4'd2: r = ua | ub;
      4'd3: r = ua & ub;
      4'd8: r = ua ^ ub;
      4'd4: begin r = ua; for (int i = 0; i < amt; i++) begin c = (r >= 32768); r = (r * 2) % 65536; end end
      4'd5: begin r = ua; for (int i = 0; i < amt; i++) begin c = (r % 2 == 1); r = r / 2; end end
      4'd6: begin r = ua; for (int i = 0; i < amt; i++) r = (r * 2) % 65536 + r / 32768; end
      4'd7: begin r = ua; for (int i = 0; i < amt; i++) r = r / 2 + (r % 2) * 32768; end
      4'd9: begin p = ua * ub; r = p % 65536; hi = p / 65536; c = (hi != 0); end
      default: e = 1;
    endcase
    z = (op == 4'd9) ? (p == 0) : (r == 0);
    x.res   = 16'(r);
    x.hi    = 16'(hi);
    x.flags = {(r >= 32768), z, c, v};
    x.err   = e;
    return x;
  endfunction

  function automatic exp_t observed();
    return {bus.result, bus.result_hi, bus.flags, bus.err};
  endfunction

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic cin);
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.cin = cin;
    while (bus.in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_accept: in_ready=%b required 1 after %0d cycles", bus.in_ready, n);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 4'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready, observed()} !== {1'b0, 1'b1, 37'b0}) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b outs=%h required 0/1/0",
               bus.out_valid, bus.in_ready, observed());
    end
  endtask

  task automatic test_directed();
    vec_t v[6];
    int lat;
    v[0] = {4'd0,  16'h0002, 16'h0001, 1'b1, {16'h0004, 16'h0000, 4'b0000, 1'b0}};
    v[1] = {4'd1,  16'h0000, 16'h0001, 1'b0, {16'hFFFF, 16'h0000, 4'b1010, 1'b0}};
    v[2] = {4'd0,  16'h7FFF, 16'h0001, 1'b0, {16'h8000, 16'h0000, 4'b1001, 1'b0}};
    v[3] = {4'd4,  16'h8001, 16'h0001, 1'b0, {16'h0002, 16'h0000, 4'b0010, 1'b0}};
    v[4] = {4'd7,  16'h0001, 16'h0004, 1'b0, {16'h1000, 16'h0000, 4'b0000, 1'b0}};
    v[5] = {4'd15, 16'h1234, 16'h5678, 1'b1, {16'h0000, 16'h0000, 4'b0100, 1'b1}};
    for (int i = 0; i < 6; i++) begin
      send(v[i].op, v[i].a, v[i].b, v[i].cin);
      wait_out(lat);
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("FAIL directed%0d_latency: got %0d required 1", i, lat);
      end
      checks++;
      if (observed() !== v[i].e) begin
        errors++;
        $display("FAIL directed%0d_result: got %h required %h", i, observed(), v[i].e);
      end
      retire();
    end
  endtask

  task automatic test_mul();
    int lat;
    int ready_high;
    exp_t want;
    want = {16'h0000, 16'h0001, 4'b0010, 1'b0};
    ready_high = 0;
    send(4'd9, 16'h0100, 16'h0100, 1'b0);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      if (bus.in_ready !== 1'b0) ready_high++;
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL mul_latency: got %0d required 16", lat); end
    checks++;
    if (ready_high !== 0) begin errors++; $display("FAIL mul_in_ready: high %0d cycles required 0", ready_high); end
    checks++;
    if (observed() !== want) begin errors++; $display("FAIL mul_result: got %h required %h", observed(), want); end
    retire();
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e0, e1;
    logic [3:0] op; logic [15:0] a, b; logic cin;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    e0 = model(4'd0, a, b, cin);
    send(4'd0, a, b, cin);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.out_valid, bus.in_ready, observed()} !== {1'b1, 1'b0, e0}) begin
        errors++;
        $display("FAIL stall%0d: valid=%b ready=%b outs=%h required 1/0/%h",
                 i, bus.out_valid, bus.in_ready, observed(), e0);
      end
      @(posedge clk); #1;
    end
    op = 4'($urandom_range(0, 8)); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    e1 = model(op, a, b, cin);
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.cin = cin;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL retire_accept_ready: got %b required 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, observed()} !== {1'b1, e1}) begin
      errors++;
      $display("FAIL retire_accept_result: valid=%b outs=%h required 1/%h", bus.out_valid, observed(), e1);
    end
    retire();
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    int stale;
    exp_t e;
    send(4'd9, 16'($urandom), 16'($urandom), 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready, observed()} !== {1'b0, 1'b1, 37'b0}) begin
      errors++;
      $display("FAIL mid_mul_reset: valid=%b ready=%b outs=%h required 0/1/0",
               bus.out_valid, bus.in_ready, observed());
    end
    stale = 0;
    repeat (20) begin
      if (bus.out_valid !== 1'b0) stale++;
      @(posedge clk); #1;
    end
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL mid_mul_stale_valid: got %0d cycles required 0", stale); end
    e = model(4'd0, 16'h1234, 16'h0FED, 1'b0);
    send(4'd0, 16'h1234, 16'h0FED, 1'b0);
    wait_out(lat);
    checks++;
    if ({lat, observed()} !== {32'd1, e}) begin
      errors++;
      $display("FAIL post_reset_add: lat=%0d outs=%h required 1/%h", lat, observed(), e);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [3:0] op; logic [15:0] a, b; logic cin;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(0, 8)); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      e = model(op, a, b, cin);
      bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.cin = cin;
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, observed()} !== {1'b1, e}) begin
        errors++;
        $display("FAIL b2b%0d: op=%0d valid=%b outs=%h required 1/%h", i, op, bus.out_valid, observed(), e);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_drain: valid=%b ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_random();
    int lat;
    exp_t e;
    logic [3:0] op; logic [15:0] a, b; logic cin;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      e = model(op, a, b, cin);
      send(op, a, b, cin);
      wait_out(lat);
      checks++;
      if (lat !== ((op == 4'd9) ? 16 : 1)) begin
        errors++;
        $display("FAIL rand%0d_latency: op=%0d got %0d", i, op, lat);
      end
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL rand%0d_result: op=%0d a=%h b=%h cin=%b got %h required %h",
                 i, op, a, b, cin, observed(), e);
      end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      retire();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
